project_io_mux: RTL and testbench

Parametrised, registered multiplexer that connects one of N user projects to the shared Caravel pads (io_out/io_oeb) and to one logic-analyser return bus. It replaces direct tristate sharing between projects with a central selector. Selection is driven by the one-hot `active` LA word, and every switch passes through a guard interval in which all pads are released and all projects are held in reset. It sits in user_project_wrapper between the project instances and the pad and LA outputs.

---
 rtl/project_mux_pkg.sv | 35 +++
 rtl/project_io_mux_sel.sv | 19 +
 rtl/project_io_mux.sv | 144 ++++++++++++++
 tb/tb_project_io_mux.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_mux_pkg.sv
// Shared types, default sizes and one-hot helpers for the project I/O multiplexer.
package project_mux_pkg;

  localparam int DEF_N_PROJ = 8;
  localparam int DEF_IO_W   = 38;
  localparam int DEF_LA_W   = 32;
  localparam int DEF_GUARD  = 4;

  // Upper bound on the project count; helpers operate on this fixed width.
  localparam int MAX_PROJ = 32;
  localparam int IDX_W    = 5;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // True when at most one bit of v is set.
  function automatic logic onehot0(input logic [MAX_PROJ-1:0] v);
    return (v & (v - MAX_PROJ'(1))) == '0;
  endfunction

  // Index of the set bit of a one-hot word; zero for an all-zero word.
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_PROJ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PROJ; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/project_io_mux_sel.sv
// AND-OR N:1 slice selector driven by a one-hot select word.
module project_io_mux_sel #(
  parameter int N = 8,
  parameter int W = 108
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  // OR together every slice masked by its select bit; an all-zero select yields zero.
  always_comb begin
    dout = '0;
    for (int p = 0; p < N; p++) begin
      dout = dout | (din[p*W +: W] & {W{sel[p]}});
    end
  end

endmodule

// File: rtl/project_io_mux.sv
// Registered selector connecting one of N user projects to the shared pads and LA
// return bus, with a guard interval (pads released, projects in reset) on every switch.
module project_io_mux
  import project_mux_pkg::*;
#(
  parameter int N_PROJ = DEF_N_PROJ,
  parameter int IO_W   = DEF_IO_W,
  parameter int LA_W   = DEF_LA_W,
  parameter int GUARD  = DEF_GUARD
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic [N_PROJ-1:0]      active_req,
  input  logic [N_PROJ*IO_W-1:0] proj_io_out,
  input  logic [N_PROJ*IO_W-1:0] proj_io_oeb,
  input  logic [N_PROJ*LA_W-1:0] proj_la_out,
  output logic [IO_W-1:0]        io_out,
  output logic [IO_W-1:0]        io_oeb,
  output logic [LA_W-1:0]        la_out,
  output logic [N_PROJ-1:0]      active_o,
  output logic [N_PROJ-1:0]      proj_rst_no,
  output logic                   conflict_o,
  output logic [CNT_W-1:0]       switch_cnt_o
);

  localparam int SEL_W  = 2*IO_W + LA_W;
  localparam int CUR_W  = $clog2(N_PROJ);
  localparam int GCNT_W = $clog2(GUARD + 1);
  localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GUARD - 1);

  state_t              state;
  logic [N_PROJ-1:0]   req_q;
  logic [CUR_W-1:0]    cur;
  logic [GCNT_W-1:0]   gcnt;

  logic [MAX_PROJ-1:0] req_wide;
  logic                req_legal;
  logic                req_nz;
  logic [CUR_W-1:0]    req_idx;
  logic [N_PROJ-1:0]   cur_oh;
  logic                hold;
  logic                data_en;

  logic [N_PROJ*SEL_W-1:0] sel_bus;
  logic [SEL_W-1:0]        sel_out;

  // Decode the registered request against the currently selected project.
  always_comb begin
    req_wide  = MAX_PROJ'(req_q);
    req_legal = onehot0(req_wide);
    req_nz    = |req_q;
    req_idx   = CUR_W'(onehot_to_index(req_wide));
    cur_oh    = N_PROJ'(1) << cur;
    hold      = (req_q == cur_oh);
    // Data flows only while staying in RUN, so the edge that leaves RUN already releases the pads.
    data_en   = (state == S_RUN) && hold;
  end

  // Pack each project's {la, oeb, out} slice so a single selector serves all three buses.
  for (genvar p = 0; p < N_PROJ; p++) begin : g_pack
    assign sel_bus[p*SEL_W +: SEL_W] = {proj_la_out[p*LA_W +: LA_W],
                                        proj_io_oeb[p*IO_W +: IO_W],
                                        proj_io_out[p*IO_W +: IO_W]};
  end

  project_io_mux_sel #(
    .N (N_PROJ),
    .W (SEL_W)
  ) u_sel (
    .sel  (cur_oh),
    .din  (sel_bus),
    .dout (sel_out)
  );

  // Request register, conflict flag and the IDLE/GUARD/RUN sequencer with its registered enables.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= S_IDLE;
      req_q        <= '0;
      cur          <= '0;
      gcnt         <= '0;
      conflict_o   <= 1'b0;
      switch_cnt_o <= '0;
      active_o     <= '0;
      proj_rst_no  <= '0;
    end else begin
      req_q      <= active_req;
      conflict_o <= !req_legal;
      case (state)
        S_IDLE: begin
          if (req_legal && req_nz) begin
            state <= S_GUARD;
            gcnt  <= GCNT_LOAD;
          end
        end
        S_GUARD: begin
          // The request is only looked at once the guard has fully elapsed.
          if (gcnt != '0) begin
            gcnt <= gcnt - GCNT_W'(1);
          end else if (req_legal && req_nz) begin
            state       <= S_RUN;
            cur         <= req_idx;
            active_o    <= req_q;
            proj_rst_no <= req_q;
            if (switch_cnt_o != {CNT_W{1'b1}}) switch_cnt_o <= switch_cnt_o + CNT_W'(1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (!hold) begin
            state       <= S_GUARD;
            gcnt        <= GCNT_LOAD;
            active_o    <= '0;
            proj_rst_no <= '0;
          end
        end
        default: begin
          state       <= S_IDLE;
          active_o    <= '0;
          proj_rst_no <= '0;
        end
      endcase
    end
  end

  // Single register stage from the selected project to the pads and LA bus; idle values otherwise.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      io_out <= '0;
      io_oeb <= '1;
      la_out <= '0;
    end else if (data_en) begin
      io_out <= sel_out[0 +: IO_W];
      io_oeb <= sel_out[IO_W +: IO_W];
      la_out <= sel_out[2*IO_W +: LA_W];
    end else begin
      io_out <= '0;
      io_oeb <= '1;
      la_out <= '0;
    end
  end

endmodule

// File: tb/tb_project_io_mux.sv
// Directed bench for project_io_mux with default parameters (8 projects, GUARD=4).
module tb_project_io_mux;

  localparam int N_PROJ = 8;
  localparam int IO_W   = 38;
  localparam int LA_W   = 32;
  localparam logic [IO_W-1:0] ALL1 = 38'h3F_FFFF_FFFF;

  logic                   clk;
  logic                   rst_n;
  logic [N_PROJ-1:0]      active_req;
  logic [N_PROJ*IO_W-1:0] proj_io_out;
  logic [N_PROJ*IO_W-1:0] proj_io_oeb;
  logic [N_PROJ*LA_W-1:0] proj_la_out;
  logic [IO_W-1:0]        io_out;
  logic [IO_W-1:0]        io_oeb;
  logic [LA_W-1:0]        la_out;
  logic [N_PROJ-1:0]      active_o;
  logic [N_PROJ-1:0]      proj_rst_no;
  logic                   conflict_o;
  logic [15:0]            switch_cnt_o;

  int errors = 0;
  int checks = 0;

  project_io_mux dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .active_req   (active_req),
    .proj_io_out  (proj_io_out),
    .proj_io_oeb  (proj_io_oeb),
    .proj_la_out  (proj_la_out),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .la_out       (la_out),
    .active_o     (active_o),
    .proj_rst_no  (proj_rst_no),
    .conflict_o   (conflict_o),
    .switch_cnt_o (switch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IO_W-1:0] exp_io(input int p);
    logic [IO_W-1:0] r;
    r = (p == 2) ? 38'h15 : (38'h20_0000_0000 | IO_W'(p));
    return r;
  endfunction

  function automatic logic [IO_W-1:0] exp_oeb(input int p);
    return IO_W'(p << 8);
  endfunction

  function automatic logic [LA_W-1:0] exp_la(input int p);
    return 32'hCAFE_0000 | LA_W'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_patterns();
    for (int p = 0; p < N_PROJ; p++) begin
      proj_io_out[p*IO_W +: IO_W] = exp_io(p);
      proj_io_oeb[p*IO_W +: IO_W] = exp_oeb(p);
      proj_la_out[p*LA_W +: LA_W] = exp_la(p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    active_req = '0;
    load_patterns();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (io_oeb !== ALL1 || active_o !== '0 || io_out !== '0) begin
      errors++;
      $display("FAIL reset_async: io_oeb=%h active_o=%h io_out=%h required oeb=%h act=0 out=0", io_oeb, active_o, io_out, ALL1);
    end
    for (int c = 0; c < 5; c++) begin
      active_req = 8'($urandom);
      for (int p = 0; p < N_PROJ; p++) begin
        proj_io_out[p*IO_W +: IO_W] = {6'($urandom), $urandom};
        proj_io_oeb[p*IO_W +: IO_W] = {6'($urandom), $urandom};
        proj_la_out[p*LA_W +: LA_W] = $urandom;
      end
      tick();
      checks++;
      if (io_oeb !== ALL1 || io_out !== '0 || la_out !== '0) begin
        errors++;
        $display("FAIL reset_pads[%0d]: oeb=%h out=%h la=%h required oeb=%h out=0 la=0", c, io_oeb, io_out, la_out, ALL1);
      end
      checks++;
      if (active_o !== '0 || proj_rst_no !== '0 || conflict_o !== 1'b0 || switch_cnt_o !== 16'h0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: act=%h rst=%h conf=%b cnt=%h required all zero", c, active_o, proj_rst_no, conflict_o, switch_cnt_o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    active_req = '0;
    load_patterns();
    tick();
  endtask

  task automatic test_switch_in();
    active_req = 8'h04;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e < 5) begin
        checks++;
        if (active_o !== '0 || io_oeb !== ALL1 || io_out !== '0) begin
          errors++;
          $display("FAIL switch_in_guard[e%0d]: act=%h oeb=%h out=%h required act=0 oeb=%h out=0", e, active_o, io_oeb, io_out, ALL1);
        end
      end else if (e == 5) begin
        checks++;
        if (active_o !== 8'h04 || proj_rst_no !== 8'h04 || io_oeb !== ALL1) begin
          errors++;
          $display("FAIL switch_in_enable: act=%h rst=%h oeb=%h required act=04 rst=04 oeb=%h", active_o, proj_rst_no, io_oeb, ALL1);
        end
      end else begin
        checks++;
        if (io_out !== 38'h15 || io_oeb !== exp_oeb(2) || la_out !== exp_la(2)) begin
          errors++;
          $display("FAIL switch_in_data: out=%h oeb=%h la=%h required out=15 oeb=%h la=%h", io_out, io_oeb, la_out, exp_oeb(2), exp_la(2));
        end
        checks++;
        if (switch_cnt_o !== 16'd1) begin
          errors++;
          $display("FAIL switch_in_cnt: cnt=%0d required 1", switch_cnt_o);
        end
      end
    end
  endtask

  task automatic test_switch_project();
    active_req = 8'h20;
    tick();
    checks++;
    if (io_out !== 38'h15 || active_o !== 8'h04) begin
      errors++;
      $display("FAIL switch_old_hold: out=%h act=%h required out=15 act=04", io_out, active_o);
    end
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (active_o !== '0 || proj_rst_no !== '0 || io_oeb !== ALL1 || io_out !== '0) begin
        errors++;
        $display("FAIL switch_released[e%0d]: act=%h rst=%h oeb=%h out=%h required act=0 rst=0 oeb=%h out=0", e, active_o, proj_rst_no, io_oeb, io_out, ALL1);
      end
    end
    tick();
    checks++;
    if (active_o !== 8'h20 || proj_rst_no !== 8'h20 || io_oeb !== ALL1) begin
      errors++;
      $display("FAIL switch_new_enable: act=%h rst=%h oeb=%h required act=20 rst=20 oeb=%h", active_o, proj_rst_no, io_oeb, ALL1);
    end
    tick();
    checks++;
    if (io_out !== exp_io(5) || io_oeb !== exp_oeb(5) || la_out !== exp_la(5)) begin
      errors++;
      $display("FAIL switch_new_data: out=%h oeb=%h la=%h required out=%h oeb=%h la=%h", io_out, io_oeb, la_out, exp_io(5), exp_oeb(5), exp_la(5));
    end
    checks++;
    if (switch_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL switch_cnt: cnt=%0d required 2", switch_cnt_o);
    end
  endtask

  task automatic test_conflict();
    active_req = 8'h04;
    for (int e = 0; e <= 6; e++) tick();
    checks++;
    if (active_o !== 8'h04 || io_out !== 38'h15 || switch_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL conflict_setup: act=%h out=%h cnt=%0d required act=04 out=15 cnt=3", active_o, io_out, switch_cnt_o);
    end
    active_req = 8'h0C;
    tick();
    tick();
    checks++;
    if (conflict_o !== 1'b1 || active_o !== '0 || io_oeb !== ALL1) begin
      errors++;
      $display("FAIL conflict_flag: conf=%b act=%h oeb=%h required conf=1 act=0 oeb=%h", conflict_o, active_o, io_oeb, ALL1);
    end
    for (int e = 2; e <= 8; e++) tick();
    checks++;
    if (active_o !== '0 || proj_rst_no !== '0 || io_out !== '0 || io_oeb !== ALL1 || la_out !== '0) begin
      errors++;
      $display("FAIL conflict_idle: act=%h rst=%h out=%h oeb=%h la=%h required idle values", active_o, proj_rst_no, io_out, io_oeb, la_out);
    end
    checks++;
    if (conflict_o !== 1'b1 || switch_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL conflict_level: conf=%b cnt=%0d required conf=1 cnt=3", conflict_o, switch_cnt_o);
    end
    active_req = '0;
    tick();
    tick();
    checks++;
    if (conflict_o !== 1'b0) begin
      errors++;
      $display("FAIL conflict_clear: conf=%b required 0", conflict_o);
    end
  endtask

  task automatic test_request_restore();
    active_req = 8'h04;
    tick();
    tick();
    active_req = '0;
    tick();
    active_req = 8'h04;
    tick();
    tick();
    checks++;
    if (active_o !== '0 || io_oeb !== ALL1) begin
      errors++;
      $display("FAIL restore_guard: act=%h oeb=%h required act=0 oeb=%h", active_o, io_oeb, ALL1);
    end
    tick();
    checks++;
    if (active_o !== 8'h04 || proj_rst_no !== 8'h04) begin
      errors++;
      $display("FAIL restore_enable: act=%h rst=%h required 04", active_o, proj_rst_no);
    end
    tick();
    checks++;
    if (io_out !== 38'h15 || la_out !== exp_la(2) || switch_cnt_o !== 16'd4) begin
      errors++;
      $display("FAIL restore_data: out=%h la=%h cnt=%0d required out=15 la=%h cnt=4", io_out, la_out, switch_cnt_o, exp_la(2));
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (active_o !== '0 || proj_rst_no !== '0 || io_oeb !== ALL1 || io_out !== '0 || la_out !== '0) begin
      errors++;
      $display("FAIL rst_run_pads: act=%h rst=%h oeb=%h out=%h la=%h required idle values", active_o, proj_rst_no, io_oeb, io_out, la_out);
    end
    checks++;
    if (switch_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL rst_run_cnt: cnt=%0d required 0", switch_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    active_req = '0;
    tick();
    tick();
    checks++;
    if (active_o !== '0 || io_oeb !== ALL1) begin
      errors++;
      $display("FAIL rst_run_after: act=%h oeb=%h required act=0 oeb=%h", active_o, io_oeb, ALL1);
    end
  endtask

  initial begin
    test_reset();
    test_switch_in();
    test_switch_project();
    test_conflict();
    test_request_restore();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
